// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with slot-level input snapshot and PWM brightness.
// Define SEG_BLINK_EN to build the blink counter and per-digit blanking of edited digits.
module seg_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 256,
    parameter int PWM_BITS  = 3,
    parameter int BLINK_DIV = 16384
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [4*DIGITS-1:0]   i_Digits_Bcd,
    input  logic [DIGITS-1:0]     i_Dots,
    input  logic [DIGITS-1:0]     i_Blink_Mask,
    input  logic [PWM_BITS-1:0]   i_Brightness,
    output logic [7:0]            o_Segments,
    output logic [DIGITS-1:0]     o_Digits,
    output logic                  o_Frame_Start
);
    localparam int SB = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SB-1:0]       scan_cnt_r;
    logic [IW-1:0]       digit_idx_r;
    logic [3:0]          snap_bcd_r;
    logic                snap_dot_r;
    logic                snap_mask_r;
    logic                snap_phase_r;
    logic [PWM_BITS-1:0] snap_bright_r;
    logic                blink_phase_s;

    logic                slot_start_s;
    logic [3:0]          cur_bcd_s;
    logic                cur_dot_s;
    logic                cur_mask_s;
    logic                cur_phase_s;
    logic [PWM_BITS-1:0] cur_bright_s;
    logic [PWM_BITS-1:0] pwm_phase_s;
    logic                lit_s;

    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        logic [6:0] segs;
        case (bcd)
            4'd0:    segs = 7'b0111111;
            4'd1:    segs = 7'b0000110;
            4'd2:    segs = 7'b1011011;
            4'd3:    segs = 7'b1001111;
            4'd4:    segs = 7'b1100110;
            4'd5:    segs = 7'b1101101;
            4'd6:    segs = 7'b1111101;
            4'd7:    segs = 7'b0000111;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1101111;
            default: segs = 7'b0000000;
        endcase
        return segs;
    endfunction

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_phase_r;

    // Blink half-period counter; phase toggles on each wrap.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + BW'(1);
        end
    end

    assign blink_phase_s = blink_phase_r;
`else
    assign blink_phase_s = 1'b0;
`endif

    // On the first cycle of a slot the live inputs are used so the output register sees them at once.
    always_comb begin
        slot_start_s = (scan_cnt_r == {SB{1'b0}});
        pwm_phase_s  = scan_cnt_r[SB-1 -: PWM_BITS];
        if (slot_start_s) begin
            cur_bcd_s    = i_Digits_Bcd[4*int'(digit_idx_r) +: 4];
            cur_dot_s    = i_Dots[digit_idx_r];
            cur_mask_s   = i_Blink_Mask[digit_idx_r];
            cur_phase_s  = blink_phase_s;
            cur_bright_s = i_Brightness;
        end else begin
            cur_bcd_s    = snap_bcd_r;
            cur_dot_s    = snap_dot_r;
            cur_mask_s   = snap_mask_r;
            cur_phase_s  = snap_phase_r;
            cur_bright_s = snap_bright_r;
        end
        lit_s = (pwm_phase_s <= cur_bright_s) && !(cur_mask_s && cur_phase_s);
    end

    // Scan counter and digit index.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            scan_cnt_r  <= {SB{1'b0}};
            digit_idx_r <= {IW{1'b0}};
        end else begin
            scan_cnt_r <= scan_cnt_r + SB'(1);
            if (scan_cnt_r == SB'(SCAN_DIV - 1)) begin
                if (digit_idx_r == IW'(DIGITS - 1)) begin
                    digit_idx_r <= {IW{1'b0}};
                end else begin
                    digit_idx_r <= digit_idx_r + IW'(1);
                end
            end else begin
                digit_idx_r <= digit_idx_r;
            end
        end
    end

    // Slot snapshot, held for the remainder of the slot.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            snap_bcd_r    <= 4'd0;
            snap_dot_r    <= 1'b0;
            snap_mask_r   <= 1'b0;
            snap_phase_r  <= 1'b0;
            snap_bright_r <= {PWM_BITS{1'b0}};
        end else if (slot_start_s) begin
            snap_bcd_r    <= cur_bcd_s;
            snap_dot_r    <= cur_dot_s;
            snap_mask_r   <= cur_mask_s;
            snap_phase_r  <= cur_phase_s;
            snap_bright_r <= cur_bright_s;
        end else begin
            snap_bcd_r    <= snap_bcd_r;
            snap_dot_r    <= snap_dot_r;
            snap_mask_r   <= snap_mask_r;
            snap_phase_r  <= snap_phase_r;
            snap_bright_r <= snap_bright_r;
        end
    end

    // Registered segment, digit-enable and frame-start outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Segments    <= 8'h00;
            o_Digits      <= {DIGITS{1'b0}};
            o_Frame_Start <= 1'b0;
        end else begin
            o_Frame_Start <= slot_start_s && (digit_idx_r == {IW{1'b0}});
            if (lit_s) begin
                o_Segments <= {cur_dot_s, seg7_decode(cur_bcd_s)};
                o_Digits   <= DIGITS'(1) << digit_idx_r;
            end else begin
                o_Segments <= 8'h00;
                o_Digits   <= {DIGITS{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=16, PWM_BITS=2, BLINK_DIV=128).
module tb_seg_scan_driver;
    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic [15:0] bcd     = 16'h0000;
    logic [3:0]  dots    = 4'b0000;
    logic [3:0]  mask    = 4'b0000;
    logic [1:0]  bright  = 2'd3;
    logic [7:0]  o_Segments;
    logic [3:0]  o_Digits;
    logic        o_Frame_Start;

    int errors = 0;
    int checks = 0;
    int c      = -1;   // index of the output cycle last sampled since reset release

    seg_scan_driver #(
        .DIGITS(4), .SCAN_DIV(16), .PWM_BITS(2), .BLINK_DIV(128)
    ) dut (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Digits_Bcd(bcd),
        .i_Dots(dots),
        .i_Blink_Mask(mask),
        .i_Brightness(bright),
        .o_Segments(o_Segments),
        .o_Digits(o_Digits),
        .o_Frame_Start(o_Frame_Start)
    );

    always #5 i_Clock = ~i_Clock;

    // Hand-written 7-segment table (g..a).
    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic exp_blank(input int cyc, input logic m);
`ifdef SEG_BLINK_EN
        return m && (((cyc / 128) % 2) == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge i_Clock);
        #1;
        c = c + 1;
    endtask

    task automatic align_frame();
        while ((c % 64) != 63) next_cycle();
    endtask

    task automatic test_reset();
        bcd = 16'h1234; dots = 4'b0010; bright = 2'd3; mask = 4'b0000;
        i_Reset = 1'b1;
        repeat (2) @(posedge i_Clock);
        #1;
        checks++; if (o_Segments !== 8'h00) begin errors++; $display("FAIL reset_segments got=%h exp=00", o_Segments); end
        checks++; if (o_Digits !== 4'b0000) begin errors++; $display("FAIL reset_digits got=%b exp=0000", o_Digits); end
        checks++; if (o_Frame_Start !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", o_Frame_Start); end
        i_Reset = 1'b0;
        c = -1;
        next_cycle();
        checks++; if (o_Frame_Start !== 1'b1) begin errors++; $display("FAIL first_frame_start got=%b exp=1", o_Frame_Start); end
        checks++; if (o_Digits !== 4'b0001) begin errors++; $display("FAIL first_digits got=%b exp=0001", o_Digits); end
        checks++; if (o_Segments !== 8'h66) begin errors++; $display("FAIL first_segments got=%h exp=66", o_Segments); end
        next_cycle();
        checks++; if (o_Frame_Start !== 1'b0) begin errors++; $display("FAIL frame_start_one_cycle got=%b exp=0", o_Frame_Start); end
    endtask

    task automatic test_normal();
        logic [7:0] tbl [4];
        int frames;
        tbl[0] = 8'h66; tbl[1] = 8'hCF; tbl[2] = 8'h5B; tbl[3] = 8'h06;
        frames = 0;
        align_frame();
        for (int i = 0; i < 128; i++) begin
            int d;
            next_cycle();
            d = (c / 16) % 4;
            if (o_Frame_Start === 1'b1) frames++;
            checks++; if (o_Digits !== (4'b0001 << d)) begin errors++; $display("FAIL normal_digits c=%0d got=%b exp=%b", c, o_Digits, 4'b0001 << d); end
            checks++; if (o_Segments !== tbl[d]) begin errors++; $display("FAIL normal_segments c=%0d got=%h exp=%h", c, o_Segments, tbl[d]); end
            checks++; if (o_Frame_Start !== ((c % 64) == 0)) begin errors++; $display("FAIL normal_frame c=%0d got=%b", c, o_Frame_Start); end
        end
        checks++; if (frames != 2) begin errors++; $display("FAIL frame_count got=%0d exp=2", frames); end
    endtask

    task automatic test_brightness();
        logic [1:0] levels [2];
        levels[0] = 2'd0; levels[1] = 2'd2;
        for (int k = 0; k < 2; k++) begin
            int lit_cnt [4];
            for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
            bright = levels[k];
            align_frame();
            for (int i = 0; i < 64; i++) begin
                int d;
                logic [3:0] ed;
                next_cycle();
                d  = (c / 16) % 4;
                ed = (((c % 16) / 4) <= int'(levels[k])) ? (4'b0001 << d) : 4'b0000;
                if (o_Digits != 4'b0000) lit_cnt[d]++;
                checks++; if (o_Digits !== ed) begin errors++; $display("FAIL bright_digits b=%0d c=%0d got=%b exp=%b", levels[k], c, o_Digits, ed); end
                if (ed == 4'b0000) begin
                    checks++; if (o_Segments !== 8'h00) begin errors++; $display("FAIL bright_off_segments c=%0d got=%h exp=00", c, o_Segments); end
                end
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (lit_cnt[d] != 4 * (int'(levels[k]) + 1)) begin
                    errors++; $display("FAIL bright_duty b=%0d digit=%0d got=%0d exp=%0d", levels[k], d, lit_cnt[d], 4 * (int'(levels[k]) + 1));
                end
            end
        end
        bright = 2'd3;
    endtask

    task automatic test_midslot_change();
        logic [7:0] tbl [4];
        tbl[0] = 8'h66; tbl[1] = 8'hCF; tbl[2] = 8'h6F; tbl[3] = 8'h06;
        align_frame();
        while ((c % 64) != 37) next_cycle();
        bcd = 16'h1934;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            checks++; if (o_Digits !== 4'b0100) begin errors++; $display("FAIL midslot_digits c=%0d got=%b exp=0100", c, o_Digits); end
            checks++; if (o_Segments !== 8'h5B) begin errors++; $display("FAIL midslot_old_value c=%0d got=%h exp=5b", c, o_Segments); end
        end
        for (int i = 0; i < 64; i++) begin
            int d;
            next_cycle();
            d = (c / 16) % 4;
            checks++; if (o_Segments !== tbl[d]) begin errors++; $display("FAIL midslot_new_value c=%0d got=%h exp=%h", c, o_Segments, tbl[d]); end
        end
        bcd = 16'h1234;
    endtask

    task automatic test_invalid_bcd();
        bcd = 16'h12FA; dots = 4'b0001;
        align_frame();
        for (int i = 0; i < 32; i++) begin
            logic [3:0] ed;
            logic [7:0] es;
            next_cycle();
            ed = (i < 16) ? 4'b0001 : 4'b0010;
            es = (i < 16) ? 8'h80 : 8'h00;
            checks++; if (o_Digits !== ed) begin errors++; $display("FAIL invalid_digits c=%0d got=%b exp=%b", c, o_Digits, ed); end
            checks++; if (o_Segments !== es) begin errors++; $display("FAIL invalid_segments c=%0d got=%h exp=%h", c, o_Segments, es); end
        end
        bcd = 16'h1234; dots = 4'b0010;
    endtask

    task automatic test_blink();
        int dark_slots;
        dark_slots = 0;
        mask = 4'b1100;
        align_frame();
        for (int i = 0; i < 384; i++) begin
            int d;
            logic [3:0] ed;
            logic [7:0] es;
            next_cycle();
            d  = (c / 16) % 4;
            ed = exp_blank(c, mask[d]) ? 4'b0000 : (4'b0001 << d);
            es = exp_blank(c, mask[d]) ? 8'h00 : {dots[d], ref_seg(bcd[4*d +: 4])};
            if ((c % 16) == 0 && ed == 4'b0000) dark_slots++;
            checks++; if (o_Digits !== ed) begin errors++; $display("FAIL blink_digits c=%0d got=%b exp=%b", c, o_Digits, ed); end
            checks++; if (o_Segments !== es) begin errors++; $display("FAIL blink_segments c=%0d got=%h exp=%h", c, o_Segments, es); end
            checks++; if ($countones(o_Digits) > 1) begin errors++; $display("FAIL one_hot c=%0d got=%b", c, o_Digits); end
        end
`ifdef SEG_BLINK_EN
        checks++; if (dark_slots == 0) begin errors++; $display("FAIL blink_seen got=%0d exp=nonzero", dark_slots); end
`endif
        mask = 4'b0000;
    endtask

    task automatic test_reset_mid();
        align_frame();
        while ((c % 64) != 40) next_cycle();
        i_Reset = 1'b1;
        @(posedge i_Clock);
        #1;
        checks++; if (o_Segments !== 8'h00) begin errors++; $display("FAIL midreset_segments got=%h exp=00", o_Segments); end
        checks++; if (o_Digits !== 4'b0000) begin errors++; $display("FAIL midreset_digits got=%b exp=0000", o_Digits); end
        checks++; if (o_Frame_Start !== 1'b0) begin errors++; $display("FAIL midreset_frame got=%b exp=0", o_Frame_Start); end
        i_Reset = 1'b0;
        c = -1;
        next_cycle();
        checks++; if (o_Frame_Start !== 1'b1) begin errors++; $display("FAIL restart_frame got=%b exp=1", o_Frame_Start); end
        checks++; if (o_Digits !== 4'b0001) begin errors++; $display("FAIL restart_digits got=%b exp=0001", o_Digits); end
        checks++; if (o_Segments !== 8'h66) begin errors++; $display("FAIL restart_segments got=%h exp=66", o_Segments); end
        for (int i = 0; i < 16; i++) next_cycle();
        checks++; if (o_Digits !== 4'b0010) begin errors++; $display("FAIL restart_second_slot got=%b exp=0010", o_Digits); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_brightness();
        test_midslot_change();
        test_invalid_bcd();
        test_blink();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
